// File: rtl/serial_tx_shifter.sv
// -----------------------------------------------------------------------------
// serial_tx_shifter
//   Loads a parallel word through a valid/ready handshake and shifts it out
//   as one bit per clock. The bit order is set by MSB_FIRST. The first bit
//   appears one cycle after the word is accepted. A new word can be accepted
//   during the final bit cycle, so consecutive frames run with no idle gap.
//
//   Optional feature: define SER_TX_PARITY_EN to add one even-parity bit
//   (the XOR of all data bits) after the data bits. That bit is sent in
//   state PARITY, so each frame is WIDTH+1 bits long.
//
// Parameters
//   WIDTH      parallel word width, 2..32
//   MSB_FIRST  1: send bit WIDTH-1 first, 0: send bit 0 first
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   din        word to serialize
//   din_valid  din is offered for transfer
//   din_ready  word accepted at this edge if din_valid is also high
//   out        serial data/parity bit
//   out_valid  out carries a real bit this cycle
//   last       out is the final bit of the frame
//   busy       a frame is in progress (state != IDLE)
//   state_dbg  current FSM state encoding, for observation only
//
// Handshake: a transfer happens on a rising edge where din_valid and
//   din_ready are both high. din_ready is combinational. It is high in IDLE
//   and during the final bit cycle of a frame. An offered word that is not
//   ready stays held by the upstream until the transfer happens.
// -----------------------------------------------------------------------------
module serial_tx_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             last,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
`ifdef SER_TX_PARITY_EN
    PARITY = 2'd2,
`endif
    IDLE   = 2'd0,
    SHIFT  = 2'd1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;   // index of the data bit currently on out
`ifdef SER_TX_PARITY_EN
  logic             par;
`endif

  logic take;

  // Bit that leaves the register next.
  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Register contents after the head bit has been removed.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign din_ready = (state == IDLE) || last;
  assign take      = din_valid && din_ready;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      last      <= 1'b0;
`ifdef SER_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else if (take) begin
      // The first bit goes straight into out. sreg keeps the remaining bits.
      state     <= SHIFT;
      sreg      <= advance(din);
      cnt       <= '0;
      out       <= head(din);
      out_valid <= 1'b1;
      last      <= 1'b0;
`ifdef SER_TX_PARITY_EN
      par       <= ^din;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef SER_TX_PARITY_EN
            state <= PARITY;
            out   <= par;
            last  <= 1'b1;
`else
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            last      <= 1'b0;
`endif
          end else begin
            cnt  <= cnt + 1'b1;
            out  <= head(sreg);
            sreg <= advance(sreg);
`ifdef SER_TX_PARITY_EN
            last <= 1'b0;
`else
            last <= (cnt == CW'(WIDTH - 2));
`endif
          end
        end
`ifdef SER_TX_PARITY_EN
        PARITY: begin
          state     <= IDLE;
          sreg      <= '0;
          cnt       <= '0;
          out       <= 1'b0;
          out_valid <= 1'b0;
          last      <= 1'b0;
        end
`endif
        default: begin
          state     <= IDLE;
          out       <= 1'b0;
          out_valid <= 1'b0;
          last      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_shifter
//   Directed bench for serial_tx_shifter with WIDTH=8. Two instances share
//   the same stimulus: u_msb uses MSB_FIRST=1 and u_lsb uses MSB_FIRST=0.
//   Expected bit sequences are written out by hand for each word. When
//   SER_TX_PARITY_EN is defined, each frame is one bit longer and ends with
//   the hand-computed parity bit.
// -----------------------------------------------------------------------------
module tb_serial_tx_shifter;

`ifdef SER_TX_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;

  logic       m_ready, m_out, m_valid, m_last, m_busy;
  logic       l_ready, l_out, l_valid, l_last, l_busy;
  logic [1:0] m_state, l_state;

  serial_tx_shifter #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .din_ready(m_ready), .out(m_out), .out_valid(m_valid), .last(m_last),
    .busy(m_busy), .state_dbg(m_state)
  );

  serial_tx_shifter #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .din_ready(l_ready), .out(l_out), .out_valid(l_valid), .last(l_last),
    .busy(l_busy), .state_dbg(l_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge. Outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " out"},       {31'd0, m_out},   32'd0);
    chk({tag, " out_valid"}, {31'd0, m_valid}, 32'd0);
    chk({tag, " last"},      {31'd0, m_last},  32'd0);
    chk({tag, " busy"},      {31'd0, m_busy},  32'd0);
    chk({tag, " din_ready"}, {31'd0, m_ready}, 32'd1);
    chk({tag, " lsb out"},   {31'd0, l_out},   32'd0);
    chk({tag, " lsb valid"}, {31'd0, l_valid}, 32'd0);
    chk({tag, " lsb busy"},  {31'd0, l_busy},  32'd0);
  endtask

  // Check one complete frame, starting in its first bit cycle.
  // msb_bits / lsb_bits hold the expected order of the data bits; bit 7 is
  // sent first. If raise_at is a valid bit index, the task offers raise_word
  // starting in that cycle.
  task automatic run_frame(input string tag, input logic [7:0] msb_bits,
                           input logic [7:0] lsb_bits, input logic par,
                           input int raise_at, input logic [7:0] raise_word);
    logic em, el, fin;
    for (int i = 0; i < FL; i++) begin
      if (i == raise_at) begin
        din       = raise_word;
        din_valid = 1'b1;
      end
      em  = (i < 8) ? msb_bits[7 - i] : par;
      el  = (i < 8) ? lsb_bits[7 - i] : par;
      fin = (i == FL - 1);
      chk($sformatf("%s b%0d out", tag, i),       {31'd0, m_out},   {31'd0, em});
      chk($sformatf("%s b%0d out_valid", tag, i), {31'd0, m_valid}, 32'd1);
      chk($sformatf("%s b%0d last", tag, i),      {31'd0, m_last},  {31'd0, fin});
      chk($sformatf("%s b%0d din_ready", tag, i), {31'd0, m_ready}, {31'd0, fin});
      chk($sformatf("%s b%0d busy", tag, i),      {31'd0, m_busy},  32'd1);
      chk($sformatf("%s b%0d lsb out", tag, i),   {31'd0, l_out},   {31'd0, el});
      chk($sformatf("%s b%0d lsb last", tag, i),  {31'd0, l_last},  {31'd0, fin});
      step();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    #3;
    check_idle("reset");
    chk("reset state_dbg", {30'd0, m_state}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single word 8'hB4 from IDLE: MSB-first order is 10110100 and
    // LSB-first order is 00101101. Even parity is 0.
    din = 8'hB4; din_valid = 1'b1;
    chk("b4 ready_idle", {31'd0, m_ready}, 32'd1);
    step();
    din_valid = 1'b0;
    run_frame("b4", 8'b10110100, 8'b00101101, 1'b0, -1, 8'h00);
    check_idle("b4 after");

    // Back-to-back: 8'hB4, then 8'h0F held valid and taken on the last bit.
    din = 8'hB4; din_valid = 1'b1;
    step();
    din = 8'h0F;
    run_frame("b2b_1", 8'b10110100, 8'b00101101, 1'b0, -1, 8'h00);
    din_valid = 1'b0;
    run_frame("b2b_2", 8'b00001111, 8'b11110000, 1'b0, -1, 8'h00);
    check_idle("b2b after");

    // 8'h07 has odd parity, so the parity bit is 1.
    din = 8'h07; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    run_frame("p07", 8'b00000111, 8'b11100000, 1'b1, -1, 8'h00);
    check_idle("p07 after");

    // Stall: 8'hAA is offered from bit 3 of 8'h35 and waits for the last bit.
    din = 8'h35; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    run_frame("stall_35", 8'b00110101, 8'b10101100, 1'b0, 3, 8'hAA);
    din_valid = 1'b0;
    run_frame("stall_aa", 8'b10101010, 8'b01010101, 1'b0, -1, 8'h00);
    check_idle("stall after");

    // Asynchronous reset after the third bit of 8'hFF.
    din = 8'hFF; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ff b%0d out", i),   {31'd0, m_out},   32'd1);
      chk($sformatf("ff b%0d valid", i), {31'd0, m_valid}, 32'd1);
      if (i < 2) step();
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    reset_n = 1'b1;

    // The first edge after reset release accepts a word.
    din = 8'h81; din_valid = 1'b1;
    chk("81 ready", {31'd0, m_ready}, 32'd1);
    step();
    din_valid = 1'b0;
    run_frame("w81", 8'b10000001, 8'b10000001, 1'b0, -1, 8'h00);
    check_idle("w81 after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
